// File: rtl/siso_pkg.sv
// Shared definitions for the SISO forward/backward recursion controller:
// FSM state encoding and watchdog sizing.
package siso_pkg;

  localparam int STW = 3;
  typedef logic [STW-1:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_INIT  = 3'd1;
  localparam state_t ST_ISSUE = 3'd2;
  localparam state_t ST_WAIT  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // Extra WAIT cycles tolerated beyond the nominal read + datapath latency.
  localparam int WATCHDOG_MARGIN = 4;

  function automatic int wd_limit(input int ram_lat, input int pipe_lat);
    return ram_lat + pipe_lat + WATCHDOG_MARGIN;
  endfunction

endpackage

// File: rtl/valid_addr_delay.sv
// Fixed-depth valid/address delay line; a depth of 0 is a combinational pass-through.
module valid_addr_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] addr_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] addr_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign valid_o = valid_i;
      assign addr_o  = addr_i;
    end else begin : g_pipe
      logic [DEPTH-1:0] vld_q;
      logic [WIDTH-1:0] addr_q [DEPTH];

      always_ff @(posedge aclk) begin
        if (!aresetn) begin
          vld_q <= '0;
          for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
        end else begin
          vld_q[0]  <= valid_i;
          addr_q[0] <= addr_i;
          for (int i = 1; i < DEPTH; i++) begin
            vld_q[i]  <= vld_q[i-1];
            addr_q[i] <= addr_q[i-1];
          end
        end
      end

      assign valid_o = vld_q[DEPTH-1];
      assign addr_o  = addr_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/siso_recursion_ctrl.sv
// Sequences one alpha (forward) or beta (backward) state-metric recursion:
// initial metric write, then one read/calc/writeback step per trellis stage.
//
// state | meaning
// IDLE  | waiting for i_start
// INIT  | write initial metric vector at o_init_addr
// ISSUE | read metrics/branches for step k
// WAIT  | wait for datapath writeback of step k (watchdog running)
// DONE  | one-cycle completion pulse, o_err flags an aborted run
module siso_recursion_ctrl
  import siso_pkg::*;
#(
  parameter int DEPTH_RAM    = 3072,
  parameter int RAM_LATENCY  = 1,
  parameter int PIPE_LATENCY = 3,
  localparam int AW          = $clog2(DEPTH_RAM)
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          i_start,
  input  logic          i_dir,
  input  logic [AW-1:0] i_len,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic          o_init,
  output logic [AW-1:0] o_init_addr,
  output logic          o_rd_en,
  output logic [AW-1:0] o_rd_addr,
  output logic          o_calc_valid,
  output logic [AW-1:0] o_calc_addr,
  input  logic          i_calc_valid,
  input  logic [AW-1:0] i_calc_addr
);

  localparam int WD_LIMIT = wd_limit(RAM_LATENCY, PIPE_LATENCY);
  localparam int WDW      = $clog2(WD_LIMIT);
  // Loaded in ISSUE and reaching zero in the last allowed WAIT cycle, so the
  // timeout DONE lands WD_LIMIT cycles after ISSUE.
  localparam logic [WDW-1:0] WD_LOAD = WDW'(WD_LIMIT - 2);

  state_t          state_q, state_d;
  logic            dir_q, dir_d;
  logic [AW-1:0]   len_q, len_d;
  logic [AW-1:0]   k_q, k_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic            err_q, err_d;

  logic [AW-1:0]   rd_addr;
  logic [AW-1:0]   wr_addr;
  logic            last_step;
  logic            issue;

  assign rd_addr   = dir_q ? (len_q - k_q) : k_q;
  assign wr_addr   = dir_q ? (len_q - k_q - AW'(1)) : (k_q + AW'(1));
  assign last_step = (k_q == (len_q - AW'(1)));
  assign issue     = (state_q == ST_ISSUE);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    len_d   = len_q;
    k_d     = k_q;
    wd_d    = wd_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          dir_d   = i_dir;
          len_d   = i_len;
          k_d     = '0;
          err_d   = 1'b0;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        state_d = (len_q == '0) ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        wd_d    = WD_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_calc_valid) begin
          if (i_calc_addr != wr_addr) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (last_step) begin
            state_d = ST_DONE;
          end else begin
            k_d     = k_q + AW'(1);
            state_d = ST_ISSUE;
          end
        end else if (wd_q == '0) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          wd_d = wd_q - WDW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      len_q   <= '0;
      k_q     <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      len_q   <= len_d;
      k_q     <= k_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  // Calc strobe trails the read by the RAM latency so data and address align.
  valid_addr_delay #(
    .DEPTH (RAM_LATENCY),
    .WIDTH (AW)
  ) u_calc_dly (
    .aclk    (aclk),
    .aresetn (aresetn),
    .valid_i (issue),
    .addr_i  (issue ? wr_addr : '0),
    .valid_o (o_calc_valid),
    .addr_o  (o_calc_addr)
  );

  assign o_busy      = (state_q == ST_INIT) || (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign o_done      = (state_q == ST_DONE);
  assign o_err       = err_q;
  assign o_init      = (state_q == ST_INIT);
  assign o_init_addr = (o_init && dir_q) ? len_q : '0;
  assign o_rd_en     = issue;
  assign o_rd_addr   = issue ? rd_addr : '0;

endmodule

// File: tb/tb_siso_recursion_ctrl.sv
// Randomized self-checking bench: expected per-cycle outputs come from the
// step-timing rules (period 5, read at +2, calc at +3) applied arithmetically.
module tb_siso_recursion_ctrl;

  localparam int DEPTH_RAM = 3072;
  localparam int AW        = 12;
  localparam int PIPE_LAT  = 3;
  localparam int F_NONE    = 0;
  localparam int F_MISM    = 1;
  localparam int F_DROP    = 2;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          i_start, i_dir;
  logic [AW-1:0] i_len;
  logic          o_busy, o_done, o_err, o_init, o_rd_en, o_calc_valid;
  logic [AW-1:0] o_init_addr, o_rd_addr, o_calc_addr;
  logic          i_calc_valid;
  logic [AW-1:0] i_calc_addr;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
  } ev_t;
  ev_t dpq[$];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  always #5 aclk = ~aclk;

  siso_recursion_ctrl #(
    .DEPTH_RAM    (DEPTH_RAM),
    .RAM_LATENCY  (1),
    .PIPE_LATENCY (PIPE_LAT)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .i_start      (i_start),
    .i_dir        (i_dir),
    .i_len        (i_len),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_init       (o_init),
    .o_init_addr  (o_init_addr),
    .o_rd_en      (o_rd_en),
    .o_rd_addr    (o_rd_addr),
    .o_calc_valid (o_calc_valid),
    .o_calc_addr  (o_calc_addr),
    .i_calc_valid (i_calc_valid),
    .i_calc_addr  (i_calc_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int rd_ref(input logic d, input int n, input int k);
    return d ? n - k : k;
  endfunction

  function automatic int wr_ref(input logic d, input int n, input int k);
    return d ? n - k - 1 : k + 1;
  endfunction

  task automatic next_cycle();
    @(posedge aclk);
    #1;
    cyc++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  o_busy, 0);
    chk({tag, "_done"},  o_done, 0);
    chk({tag, "_err"},   o_err, 0);
    chk({tag, "_init"},  o_init, 0);
    chk({tag, "_rd"},    o_rd_en, 0);
    chk({tag, "_calc"},  o_calc_valid, 0);
    chk({tag, "_iaddr"}, o_init_addr, 0);
    chk({tag, "_raddr"}, o_rd_addr, 0);
    chk({tag, "_caddr"}, o_calc_addr, 0);
  endtask

  // One recursion: fault kind/step fj shape the datapath model; noise adds
  // ignored starts and stray writebacks; rst_at>0 pulls reset in that cycle.
  task automatic run(input logic dir, input int n, input int fault, input int fj,
                     input bit noise, input int rst_at);
    int steps, end_t, last_t, kk;
    bit ex_rd, ex_calc, post;
    steps  = (fault == F_NONE) ? n : fj + 1;
    end_t  = (n == 0) ? 2 :
             (fault == F_MISM) ? 7 + 5 * fj :
             (fault == F_DROP) ? 10 + 5 * fj : 2 + 5 * n;
    last_t = (rst_at != 0) ? rst_at + 4 : end_t + 2;
    kk = 0;
    dpq.delete();

    next_cycle();
    i_start = 1'b1; i_dir = dir; i_len = AW'(n); i_calc_valid = 1'b0;
    @(negedge aclk);
    chk("idle_busy", o_busy, 0);

    for (int t = 1; t <= last_t; t++) begin
      post    = (rst_at != 0) && (t > rst_at);
      ex_rd   = !post && t >= 2 && t < end_t && ((t - 2) % 5 == 0) && ((t - 2) / 5 < steps);
      ex_calc = !post && t >= 3 && ((t - 3) % 5 == 0) && ((t - 3) / 5 < steps);
      next_cycle();
      i_start      = 1'b0;
      i_dir        = 1'($urandom);
      i_len        = AW'($urandom);
      i_calc_valid = 1'b0;
      i_calc_addr  = AW'($urandom);
      aresetn      = (t == rst_at) ? 1'b0 : 1'b1;
      if (!post && (t == end_t || (noise && t == 4 && steps > 0))) i_start = 1'b1;
      if (!post && dpq.size() > 0 && dpq[0].due == t) begin
        i_calc_valid = 1'b1;
        i_calc_addr  = dpq[0].addr;
        void'(dpq.pop_front());
      end else if (!post && noise && (t == 1 || ex_rd || t > end_t)) begin
        i_calc_valid = 1'b1;
      end
      @(negedge aclk);
      if (post) begin
        chk_all_zero("rst");
      end else begin
        chk("busy",  o_busy, (t < end_t) ? 1 : 0);
        chk("done",  o_done, (t == end_t) ? 1 : 0);
        chk("init",  o_init, (t == 1) ? 1 : 0);
        chk("rd_en", o_rd_en, ex_rd ? 1 : 0);
        chk("calc",  o_calc_valid, ex_calc ? 1 : 0);
        chk("err",   o_err, (fault != F_NONE && t >= end_t) ? 1 : 0);
        if (t == 1) chk("init_addr", o_init_addr, dir ? n : 0);
        if (ex_rd) chk("rd_addr", o_rd_addr, rd_ref(dir, n, (t - 2) / 5));
        if (ex_calc) chk("calc_addr", o_calc_addr, wr_ref(dir, n, (t - 3) / 5));
      end
      if (o_calc_valid) begin
        if (!(fault == F_DROP && kk == fj)) begin
          if (fault == F_MISM && kk == fj)
            dpq.push_back('{due: t + PIPE_LAT, addr: o_calc_addr - AW'(1)});
          else
            dpq.push_back('{due: t + PIPE_LAT, addr: o_calc_addr});
        end
        kk++;
      end
    end
    aresetn = 1'b1;
    dpq.delete();
  endtask

  initial begin
    int n, f, j;
    aresetn = 1'b0; i_start = 1'b0; i_dir = 1'b0; i_len = '0;
    i_calc_valid = 1'b0; i_calc_addr = '0;
    repeat (3) next_cycle();
    @(negedge aclk);
    chk_all_zero("reset");
    next_cycle();
    aresetn = 1'b1;

    run(1'b0, 3, F_NONE, 0, 1'b0, 0);
    run(1'b1, 4, F_NONE, 0, 1'b0, 0);
    run(1'b0, 0, F_NONE, 0, 1'b0, 0);
    run(1'b0, 4, F_MISM, 2, 1'b0, 0);
    run(1'b0, 3, F_NONE, 0, 1'b1, 0);
    run(1'b0, 3, F_DROP, 1, 1'b0, 0);
    run(1'b1, 4, F_NONE, 0, 1'b1, 7);
    run(1'b1, 4, F_NONE, 0, 1'b0, 0);
    run(1'b1, 1, F_NONE, 0, 1'b1, 0);

    for (int r = 0; r < 40; r++) begin
      n = $urandom_range(0, 8);
      f = (n == 0) ? F_NONE : $urandom_range(0, 2);
      j = (n == 0) ? 0 : $urandom_range(0, n - 1);
      run(1'($urandom), n, f, j, 1'($urandom), 0);
    end

    run(1'b1, DEPTH_RAM - 1, F_NONE, 0, 1'b0, 0);
    run(1'b0, DEPTH_RAM - 1, F_DROP, 5, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/siso_recursion_ctrl.md
SISO_RECURSION_CTRL -- requirements
Module: siso_recursion_ctrl

Interface
REQ-001 Parameter DEPTH_RAM, 3072: state-metric RAM depth; AW = $clog2(DEPTH_RAM).
REQ-002 Parameter RAM_LATENCY, 1: cycles from o_rd_en to read data valid at datapath inputs.
REQ-003 Parameter PIPE_LATENCY, 3: row-calc datapath latency from i_valid to o_valid.
REQ-004 aclk  in  1  clock; all logic on rising edge.
REQ-005 aresetn  in  1  reset, synchronous, active-low.
REQ-006 i_start  in  1  one-cycle request to run one recursion.
REQ-007 i_dir  in  1  0 = forward (alpha), 1 = backward (beta); sampled with i_start.
REQ-008 i_len  in  AW  trellis length N, 0..DEPTH_RAM-1; sampled with i_start.
REQ-009 o_busy  out  1  high from accepted start until o_done.
REQ-010 o_done  out  1  one-cycle completion pulse.
REQ-011 o_err  out  1  high with o_done on an aborted run; held until the next accepted start.
REQ-012 o_init  out  1  one-cycle strobe to write the initial metric vector at o_init_addr.
REQ-013 o_init_addr  out  AW  0 (forward) or N (backward).
REQ-014 o_rd_en / o_rd_addr  out  1 / AW  metric and branch RAM read request.
REQ-015 o_calc_valid / o_calc_addr  out  1 / AW  drives datapath i_valid / i_addr.
REQ-016 i_calc_valid / i_calc_addr  in  1 / AW  datapath o_valid / o_addr (writeback monitor).

Function
REQ-017 States: IDLE, INIT, ISSUE, WAIT, DONE.
REQ-018 IDLE: i_start=1 latches i_dir and i_len, then goes to INIT; i_start outside IDLE is ignored.
REQ-019 INIT (1 cycle): o_init=1; goes to DONE if N=0, else to ISSUE.
REQ-020 Step k (0..N-1), forward: read address r=k, write address w=k+1; backward: r=N-k, w=N-k-1.
REQ-021 ISSUE (1 cycle): o_rd_en=1, o_rd_addr=r; then WAIT.
REQ-022 Exactly RAM_LATENCY cycles after ISSUE: o_calc_valid=1 for 1 cycle, o_calc_addr=w (internal delay line).
REQ-023 WAIT: exit on i_calc_valid=1. If i_calc_addr=w and k<N-1, go to ISSUE next cycle. If i_calc_addr=w and k=N-1, go to DONE.
REQ-024 Step period: RAM_LATENCY+PIPE_LATENCY+1 cycles, which is 5 with default parameters. The next read follows writeback by 1 cycle so the written metric is committed first.
REQ-025 Address mismatch (i_calc_valid=1, i_calc_addr!=w): set o_err, go to DONE.
REQ-026 Watchdog: a WAIT counter starts at ISSUE. If no i_calc_valid within RAM_LATENCY+PIPE_LATENCY+4 cycles, set o_err and go to DONE.
REQ-027 i_calc_valid outside WAIT is ignored; it shall not change the state or o_err.
REQ-028 DONE (1 cycle): o_done=1, o_busy=0; then IDLE. A start in the DONE cycle is ignored.
REQ-029 o_busy=1 in INIT, ISSUE and WAIT.
REQ-030 Address arithmetic is unsigned AW-bit; k never exceeds N-1, so there is no wrap-around.

Reset
REQ-031 aresetn=0 at the next edge: state=IDLE; o_busy, o_done, o_err, o_init, o_rd_en and o_calc_valid =0; all addresses, counters and the delay line =0.
REQ-032 Reset mid-run: the run is abandoned without o_done; a pending o_calc_valid in the delay line is discarded.

Structure
REQ-033 The state encoding and the WATCHDOG_MARGIN=4 constant reside in shared package siso_pkg.
REQ-034 The delay line is sub-module valid_addr_delay, parameterised by depth and width, and reusable.
REQ-035 The datapath and RAMs are external; this block issues no arithmetic on metrics.

Verification
REQ-036 Forward, N=3, datapath model latency 3: o_init_addr=0; reads 0,1,2 at period 5; calc addrs 1,2,3; o_done at cycle 17 after start; o_err=0.
REQ-037 Backward, N=4: o_init_addr=4; reads 4,3,2,1; calc addrs 3,2,1,0; o_done with o_err=0.
REQ-038 N=0: o_init pulse, o_done on the following cycle, no o_rd_en.
REQ-039 Model returns i_calc_addr=2 when 3 is expected: o_err=1 with o_done, then IDLE; o_err clears on the next start.
REQ-040 Model drops one o_valid: watchdog fires 8 cycles after ISSUE, giving o_err=1 and o_done.
REQ-041 i_start pulsed during WAIT and aresetn=0 during step 2: start ignored; after reset all outputs are 0, no o_done occurs, and a new run completes normally.
